// File: rtl/stream_demux_n.sv
// Routes one valid/ready input stream to one of CH_NUM registered output slots,
// with optional per-packet route locking and a saturating count of discarded beats.
module stream_demux_n #(
    parameter int DATA_WD  = 4,
    parameter int CH_NUM   = 4,
    parameter int SEL_WD   = 2,
    parameter int PKT_MODE = 1,
    parameter int CNT_WD   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_WD-1:0]         sel,
    input  logic                      s_valid,
    input  logic [DATA_WD-1:0]        s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [CH_NUM-1:0]         m_valid,
    output logic [CH_NUM*DATA_WD-1:0] m_data,
    output logic [CH_NUM-1:0]         m_last,
    input  logic [CH_NUM-1:0]         m_ready,
    output logic                      busy,
    output logic [CNT_WD-1:0]         drop_cnt
);

    localparam int                SEL_SPAN = 1 << SEL_WD;
    localparam logic [SEL_WD:0]   CH_LIM   = (SEL_WD + 1)'(CH_NUM);
    localparam logic [CNT_WD-1:0] CNT_MAX  = {CNT_WD{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t              state_r;
    logic [SEL_WD-1:0]   lock_sel_r;
    logic [SEL_WD-1:0]   eff_sel_s;
    logic                in_range_s;
    logic [SEL_SPAN-1:0] slot_free_s;
    logic                fire_s;
    logic                last_in_s;
    logic [CH_NUM-1:0]   load_s;

    // Route resolution and input handshake; unused select codes read as always-free
    // so out-of-range beats are accepted and discarded.
    always_comb begin
        if (state_r == ST_PKT) begin
            eff_sel_s = lock_sel_r;
        end else begin
            eff_sel_s = sel;
        end
        in_range_s  = ({1'b0, eff_sel_s} < CH_LIM);
        slot_free_s = {SEL_SPAN{1'b1}};
        for (int i = 0; i < CH_NUM; i++) begin
            slot_free_s[i] = !m_valid[i] || m_ready[i];
        end
        s_ready   = slot_free_s[eff_sel_s];
        fire_s    = s_valid && s_ready;
        last_in_s = (PKT_MODE != 0) ? s_last : 1'b0;
        load_s    = {CH_NUM{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            load_s[i] = fire_s && (eff_sel_s == SEL_WD'(i));
        end
    end

    // Per-channel output slots: a load beats a simultaneous drain to keep 1 beat/cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= {CH_NUM{1'b0}};
            m_data  <= {(CH_NUM * DATA_WD){1'b0}};
            m_last  <= {CH_NUM{1'b0}};
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (load_s[i]) begin
                    m_valid[i]                     <= 1'b1;
                    m_data[i*DATA_WD +: DATA_WD]   <= s_data;
                    m_last[i]                      <= last_in_s;
                end else if (m_valid[i] && m_ready[i]) begin
                    m_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Packet tracker: the route of a multi-beat packet is frozen at its first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            lock_sel_r <= {SEL_WD{1'b0}};
            busy       <= 1'b0;
        end else if ((PKT_MODE != 0) && fire_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!s_last) begin
                        state_r    <= ST_PKT;
                        lock_sel_r <= sel;
                        busy       <= 1'b1;
                    end
                end
                ST_PKT: begin
                    if (s_last) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of beats discarded for lack of a destination channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= {CNT_WD{1'b0}};
        end else if (fire_s && !in_range_s && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + CNT_WD'(1);
        end
    end

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: four configurations share one stimulus stream and are
// checked against a per-instance behavioural model plus directed scenario checks.
module tb_stream_demux_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       s_valid;
    logic [3:0] s_data;
    logic       s_last;
    logic [3:0] m_ready;

    logic        sr_a, sr_b, sr_c, sr_d, bz_a, bz_b, bz_c, bz_d;
    logic [3:0]  mv_a, ml_a, mv_b, ml_b;
    logic [2:0]  mv_c, ml_c, mv_d, ml_d;
    logic [15:0] md_a, md_b;
    logic [11:0] md_c, md_d;
    logic [7:0]  dc_a, dc_b, dc_d;
    logic [1:0]  dc_c;

    logic        sr [4];
    logic        bz [4];
    logic [3:0]  mv [4];
    logic [3:0]  ml [4];
    logic [15:0] md [4];
    logic [7:0]  dc [4];

    int n_vec = 0;
    int n_err = 0;

    // Instance configuration: channel count, packet mode, drop counter ceiling.
    int ch_n [4] = '{4, 4, 3, 3};
    int pm   [4] = '{0, 1, 1, 0};
    int dmax [4] = '{255, 255, 3, 255};

    // Behavioural model state per instance.
    bit       m_v    [4][4];
    bit [3:0] m_d    [4][4];
    bit       m_l    [4][4];
    bit       m_pkt  [4];
    int       m_lock [4];
    int       m_drop [4];

    always #5 clk = ~clk;

    stream_demux_n #(.DATA_WD(4), .CH_NUM(4), .SEL_WD(2), .PKT_MODE(0), .CNT_WD(8)) dut_a (
        .clk(clk), .rst(rst), .sel(sel), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(sr_a), .m_valid(mv_a), .m_data(md_a), .m_last(ml_a), .m_ready(m_ready),
        .busy(bz_a), .drop_cnt(dc_a));
    stream_demux_n #(.DATA_WD(4), .CH_NUM(4), .SEL_WD(2), .PKT_MODE(1), .CNT_WD(8)) dut_b (
        .clk(clk), .rst(rst), .sel(sel), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(sr_b), .m_valid(mv_b), .m_data(md_b), .m_last(ml_b), .m_ready(m_ready),
        .busy(bz_b), .drop_cnt(dc_b));
    stream_demux_n #(.DATA_WD(4), .CH_NUM(3), .SEL_WD(2), .PKT_MODE(1), .CNT_WD(2)) dut_c (
        .clk(clk), .rst(rst), .sel(sel), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(sr_c), .m_valid(mv_c), .m_data(md_c), .m_last(ml_c), .m_ready(m_ready[2:0]),
        .busy(bz_c), .drop_cnt(dc_c));
    stream_demux_n #(.DATA_WD(4), .CH_NUM(3), .SEL_WD(2), .PKT_MODE(0), .CNT_WD(8)) dut_d (
        .clk(clk), .rst(rst), .sel(sel), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(sr_d), .m_valid(mv_d), .m_data(md_d), .m_last(ml_d), .m_ready(m_ready[2:0]),
        .busy(bz_d), .drop_cnt(dc_d));

    always_comb begin
        sr[0] = sr_a; sr[1] = sr_b; sr[2] = sr_c; sr[3] = sr_d;
        bz[0] = bz_a; bz[1] = bz_b; bz[2] = bz_c; bz[3] = bz_d;
        mv[0] = mv_a; mv[1] = mv_b; mv[2] = {1'b0, mv_c}; mv[3] = {1'b0, mv_d};
        ml[0] = ml_a; ml[1] = ml_b; ml[2] = {1'b0, ml_c}; ml[3] = {1'b0, ml_d};
        md[0] = md_a; md[1] = md_b; md[2] = {4'h0, md_c}; md[3] = {4'h0, md_d};
        dc[0] = dc_a; dc[1] = dc_b; dc[2] = {6'b0, dc_c}; dc[3] = dc_d;
    end

    function automatic int model_eff(int k);
        return (pm[k] != 0 && m_pkt[k]) ? m_lock[k] : int'(sel);
    endfunction

    function automatic bit model_ready(int k);
        int e = model_eff(k);
        if (e >= ch_n[k]) return 1'b1;
        return !m_v[k][e] || m_ready[e];
    endfunction

    function automatic logic [3:0] model_mv(int k);
        logic [3:0] r = 4'b0;
        for (int i = 0; i < 4; i++) r[i] = m_v[k][i];
        return r;
    endfunction

    function automatic logic [3:0] model_ml(int k);
        logic [3:0] r = 4'b0;
        for (int i = 0; i < 4; i++) r[i] = m_l[k][i];
        return r;
    endfunction

    function automatic logic [15:0] model_md(int k);
        logic [15:0] r = 16'h0;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = m_d[k][i];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_v[k][i] = 1'b0; m_d[k][i] = 4'h0; m_l[k][i] = 1'b0;
            end
            m_pkt[k] = 1'b0; m_lock[k] = 0; m_drop[k] = 0;
        end
    endtask

    // One clock: decide fires from pre-edge inputs, then advance the model at the edge.
    task automatic tick();
        bit f [4];
        int e [4];
        for (int k = 0; k < 4; k++) begin
            e[k] = model_eff(k);
            f[k] = s_valid && model_ready(k);
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < ch_n[k]; i++)
                if (m_v[k][i] && m_ready[i]) m_v[k][i] = 1'b0;
            if (f[k]) begin
                if (e[k] < ch_n[k]) begin
                    m_v[k][e[k]] = 1'b1;
                    m_d[k][e[k]] = s_data;
                    m_l[k][e[k]] = (pm[k] != 0) ? s_last : 1'b0;
                end else if (m_drop[k] < dmax[k]) begin
                    m_drop[k]++;
                end
                if (pm[k] != 0) begin
                    if (!m_pkt[k]) begin
                        if (!s_last) begin m_pkt[k] = 1'b1; m_lock[k] = int'(sel); end
                    end else if (s_last) begin
                        m_pkt[k] = 1'b0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        s_valid = 1'b0; sel = 2'd0; s_data = 4'h0; s_last = 1'b0; m_ready = 4'b1111;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (mv[k] !== 4'b0) begin n_err++; $display("FAIL reset_mv inst%0d got %b want 0000", k, mv[k]); end
            n_vec++; if (md[k] !== 16'h0) begin n_err++; $display("FAIL reset_md inst%0d got %h want 0000", k, md[k]); end
            n_vec++; if (bz[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy inst%0d got %b want 0", k, bz[k]); end
            n_vec++; if (dc[k] !== 8'd0) begin n_err++; $display("FAIL reset_drop inst%0d got %0d want 0", k, dc[k]); end
        end
    endtask

    task automatic test_basic();
        sel = 2'd2; s_data = 4'h3; s_last = 1'b0; s_valid = 1'b1; m_ready = 4'b1111;
        #1;
        n_vec++; if (sr_a !== 1'b1) begin n_err++; $display("FAIL basic_ready got %b want 1", sr_a); end
        tick();
        n_vec++; if (mv_a !== 4'b0100) begin n_err++; $display("FAIL basic_mv got %b want 0100", mv_a); end
        n_vec++; if (md_a[11:8] !== 4'h3) begin n_err++; $display("FAIL basic_md got %h want 3", md_a[11:8]); end
        for (int j = 0; j < 4; j++) begin
            s_data = 4'(j + 4);
            #1;
            n_vec++; if (sr_a !== 1'b1) begin n_err++; $display("FAIL b2b_ready beat%0d got %b want 1", j, sr_a); end
            tick();
            n_vec++; if (md_a[11:8] !== 4'(j + 4) || mv_a !== 4'b0100) begin
                n_err++; $display("FAIL b2b_data beat%0d got %h/%b want %h/0100", j, md_a[11:8], mv_a, 4'(j + 4));
            end
        end
        s_valid = 1'b0;
        tick();
        n_vec++; if (mv_a !== 4'b0000) begin n_err++; $display("FAIL basic_drain got %b want 0000", mv_a); end
    endtask

    task automatic test_backpressure();
        m_ready = 4'b1101; sel = 2'd1; s_data = 4'h5; s_last = 1'b1; s_valid = 1'b1;
        #1;
        n_vec++; if (sr_a !== 1'b1) begin n_err++; $display("FAIL bp_first_ready got %b want 1", sr_a); end
        tick();
        s_data = 4'h6;
        #1;
        n_vec++; if (sr_a !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready got %b want 0", sr_a); end
        tick();
        n_vec++; if (md_a[7:4] !== 4'h5 || mv_a[1] !== 1'b1) begin
            n_err++; $display("FAIL bp_hold got %h/%b want 5/1", md_a[7:4], mv_a[1]);
        end
        sel = 2'd0; s_data = 4'h7;
        #1;
        n_vec++; if (sr_a !== 1'b1) begin n_err++; $display("FAIL bp_other_ready got %b want 1", sr_a); end
        tick();
        n_vec++; if (mv_a !== 4'b0011 || md_a[3:0] !== 4'h7) begin
            n_err++; $display("FAIL bp_other got %b/%h want 0011/7", mv_a, md_a[3:0]);
        end
        sel = 2'd1; s_data = 4'h6; m_ready = 4'b1111;
        #1;
        n_vec++; if (sr_a !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", sr_a); end
        tick();
        n_vec++; if (mv_a !== 4'b0010 || md_a[7:4] !== 4'h6) begin
            n_err++; $display("FAIL bp_release got %b/%h want 0010/6", mv_a, md_a[7:4]);
        end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_packet();
        do_reset();
        m_ready = 4'b1111; s_valid = 1'b1; sel = 2'd3; s_data = 4'h1; s_last = 1'b0;
        tick();
        n_vec++; if (bz_b !== 1'b1 || mv_b !== 4'b1000 || md_b[15:12] !== 4'h1 || ml_b[3] !== 1'b0) begin
            n_err++; $display("FAIL pkt_beat1 got busy=%b mv=%b d=%h l=%b want 1/1000/1/0", bz_b, mv_b, md_b[15:12], ml_b[3]);
        end
        sel = 2'd0; s_data = 4'h2;
        tick();
        n_vec++; if (bz_b !== 1'b1 || mv_b !== 4'b1000 || md_b[15:12] !== 4'h2) begin
            n_err++; $display("FAIL pkt_beat2 got busy=%b mv=%b d=%h want 1/1000/2", bz_b, mv_b, md_b[15:12]);
        end
        sel = 2'd1; s_data = 4'h3; s_last = 1'b1;
        #1;
        n_vec++; if (sr_b !== 1'b1) begin n_err++; $display("FAIL pkt_ready got %b want 1", sr_b); end
        tick();
        n_vec++; if (bz_b !== 1'b0 || mv_b !== 4'b1000 || md_b[15:12] !== 4'h3 || ml_b[3] !== 1'b1) begin
            n_err++; $display("FAIL pkt_last got busy=%b mv=%b d=%h l=%b want 0/1000/3/1", bz_b, mv_b, md_b[15:12], ml_b[3]);
        end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        s_valid = 1'b1; sel = 2'd1; s_data = 4'h9; s_last = 1'b1;
        tick();
        n_vec++; if (bz_b !== 1'b0 || mv_b !== 4'b0010 || ml_b[1] !== 1'b1) begin
            n_err++; $display("FAIL single got busy=%b mv=%b l=%b want 0/0010/1", bz_b, mv_b, ml_b[1]);
        end
        sel = 2'd2; s_data = 4'hA; s_last = 1'b0;
        tick();
        n_vec++; if (mv_b !== 4'b0100 || md_b[11:8] !== 4'hA || bz_b !== 1'b1) begin
            n_err++; $display("FAIL single_next got mv=%b d=%h busy=%b want 0100/a/1", mv_b, md_b[11:8], bz_b);
        end
        s_data = 4'hB; s_last = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_drop();
        do_reset();
        m_ready = 4'b1111; s_valid = 1'b1; sel = 2'd3; s_last = 1'b1;
        for (int j = 0; j < 5; j++) begin
            s_data = 4'(j);
            #1;
            n_vec++; if (sr_d !== 1'b1) begin n_err++; $display("FAIL drop_ready beat%0d got %b want 1", j, sr_d); end
            tick();
            n_vec++; if (mv_d !== 3'b000) begin n_err++; $display("FAIL drop_mv beat%0d got %b want 000", j, mv_d); end
        end
        n_vec++; if (dc_d !== 8'd5) begin n_err++; $display("FAIL drop_cnt got %0d want 5", dc_d); end
        n_vec++; if (dc_c !== 2'd3) begin n_err++; $display("FAIL drop_sat got %0d want 3", dc_c); end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        m_ready = 4'b0000; s_valid = 1'b1; sel = 2'd2; s_data = 4'h5; s_last = 1'b0;
        tick();
        sel = 2'd0; s_data = 4'h6;
        tick();
        n_vec++; if (bz_b !== 1'b1 || mv_a !== 4'b0101) begin
            n_err++; $display("FAIL areset_pre got busy=%b mv=%b want 1/0101", bz_b, mv_a);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (mv[k] !== 4'b0 || bz[k] !== 1'b0 || dc[k] !== 8'd0) begin
                n_err++; $display("FAIL areset inst%0d got mv=%b busy=%b drop=%0d want 0/0/0", k, mv[k], bz[k], dc[k]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sel = 2'd1; s_data = 4'h4; s_last = 1'b1; m_ready = 4'b1111;
        tick();
        n_vec++; if (mv_b !== 4'b0010 || md_b[7:4] !== 4'h4) begin
            n_err++; $display("FAIL areset_post got mv=%b d=%h want 0010/4", mv_b, md_b[7:4]);
        end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            sel     = 2'($urandom_range(3, 0));
            s_valid = ($urandom_range(3, 0) != 0);
            s_data  = 4'($urandom);
            s_last  = ($urandom_range(2, 0) == 0);
            m_ready = 4'($urandom);
            #1;
            for (int k = 0; k < 4; k++) begin
                n_vec++; if (sr[k] !== model_ready(k)) begin
                    n_err++; $display("FAIL rnd_ready cyc%0d inst%0d got %b want %b", c, k, sr[k], model_ready(k));
                end
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                n_vec++; if (mv[k] !== model_mv(k)) begin
                    n_err++; $display("FAIL rnd_mv cyc%0d inst%0d got %b want %b", c, k, mv[k], model_mv(k));
                end
                n_vec++; if (md[k] !== model_md(k)) begin
                    n_err++; $display("FAIL rnd_md cyc%0d inst%0d got %h want %h", c, k, md[k], model_md(k));
                end
                n_vec++; if (ml[k] !== model_ml(k)) begin
                    n_err++; $display("FAIL rnd_ml cyc%0d inst%0d got %b want %b", c, k, ml[k], model_ml(k));
                end
                n_vec++; if (bz[k] !== m_pkt[k]) begin
                    n_err++; $display("FAIL rnd_busy cyc%0d inst%0d got %b want %b", c, k, bz[k], m_pkt[k]);
                end
                n_vec++; if (dc[k] !== 8'(m_drop[k])) begin
                    n_err++; $display("FAIL rnd_drop cyc%0d inst%0d got %0d want %0d", c, k, dc[k], m_drop[k]);
                end
            end
        end
        s_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        sel = 2'd0; s_valid = 1'b0; s_data = 4'h0; s_last = 1'b0; m_ready = 4'b1111;
        #12;
        test_reset();
        test_basic();
        test_backpressure();
        test_packet();
        test_single();
        test_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised successor to the 2-way stream demux: routes one valid/ready input stream to one of CH_NUM output channels.
- Adds registered outputs with full throughput, a per-channel output slot, and optional packet mode where the route is locked from first beat to s_last.
- Out-of-range selects are accepted and discarded, and counted.
- Sits between a single producer (DMA/parser) and per-destination consumers in the stream fabric.

Parameters:
- DATA_WD, 4: payload width in bits.
- CH_NUM, 4: number of output channels, 2..2^SEL_WD.
- SEL_WD, 2: width of sel.
- PKT_MODE, 1: 1 = route locked per packet (s_last delimited); 0 = route chosen per beat.
- CNT_WD, 8: width of drop counter.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  asynchronous active-high reset.
- sel  input  SEL_WD  requested output channel.
- s_valid  input  1  input beat valid.
- s_data  input  DATA_WD  input payload.
- s_last  input  1  last beat of packet (ignored when PKT_MODE=0).
- s_ready  output  1  input accepted this cycle when s_valid is also high.
- m_valid  output  CH_NUM  per-channel valid.
- m_data  output  CH_NUM*DATA_WD  per-channel payload; channel i at bits [i*DATA_WD +: DATA_WD].
- m_last  output  CH_NUM  per-channel last flag.
- m_ready  input  CH_NUM  per-channel ready.
- busy  output  1  high while a packet is in progress (state PKT).
- drop_cnt  output  CNT_WD  number of beats discarded due to out-of-range route.

Behaviour:
Reset:
- rst asserted (any time, asynchronous) forces: m_valid=0, m_data=0, m_last=0, state=IDLE, lock_sel=0, busy=0, drop_cnt=0.
- Reset mid-packet abandons the packet; beats held in output slots are lost.

Route selection:
- eff_sel = lock_sel when state=PKT, else sel.
- PKT_MODE=0: state stays IDLE and eff_sel = sel every beat.

Input handshake:
- slot_free[i] = !m_valid[i] || m_ready[i].
- s_ready = 1 if eff_sel >= CH_NUM, else slot_free[eff_sel].
- s_ready never depends on s_valid.
- fire = s_valid && s_ready.

Output slots:
- On fire with eff_sel = i < CH_NUM: m_valid[i] <= 1, m_data[i] <= s_data, m_last[i] <= s_last (0 when PKT_MODE=0).
- Otherwise, when m_valid[i] && m_ready[i]: m_valid[i] <= 0. m_data and m_last hold their values.
- Load and drain on the same channel in the same cycle: load wins and m_valid stays 1, giving 1 beat/cycle per channel.
- Once m_valid[i] is high, m_data[i] and m_last[i] stay stable until m_ready[i].
- Latency: input fire to m_valid is 1 cycle.
- Non-selected channels keep draining independently; a stalled channel blocks only beats routed to it.

Packet FSM (PKT_MODE=1):
- IDLE: on fire && !s_last -> PKT and lock_sel <= sel. On fire && s_last (single-beat packet) -> stay IDLE.
- PKT: on fire && s_last -> IDLE. sel changes are ignored while in PKT.
- busy = (state==PKT).

Drop:
- On fire with eff_sel >= CH_NUM, the beat is discarded and drop_cnt increments by 1, saturating at 2^CNT_WD-1.
- In PKT_MODE=1, a packet locked to an out-of-range channel is dropped beat by beat and the FSM still tracks s_last.

Test Plan:
- Reset then PKT_MODE=0, sel=2, data 0x3, all m_ready=1 -> m_valid=4'b0100 and m_data[2]=0x3 one cycle after fire; s_ready stays 1; back-to-back beats sustain 1/cycle.
- Backpressure: m_ready[1]=0, two beats to ch1 -> first held in slot with stable data, s_ready=0 for the second; a beat to ch0 in the same window still passes; raising m_ready[1] drains the slot and accepts the second beat next cycle.
- PKT_MODE=1: 3-beat packet (0x1,0x2,0x3 with last on 0x3) starting with sel=3, sel toggled mid-packet -> all beats on ch3; busy high after beat 1 until the last fire; m_last[3]=1 only with 0x3.
- Single-beat packet with s_last=1 and sel=1 -> busy stays 0; the next beat re-samples sel.
- Out-of-range: CH_NUM=3, sel=3, 5 beats -> s_ready=1, no m_valid, drop_cnt=5; with CNT_WD=2 and 5 beats, drop_cnt saturates at 3.
- Async reset asserted mid-packet with slots full -> m_valid=0, busy=0, drop_cnt=0 immediately without a clock edge; after release the first beat routes by the current sel.
